// File: rtl/fpio_fifo_in_arbiter.sv
// Purpose : round-robin, burst-locked arbiter sharing one FPIO FIFO-in write port among NUM_REQ requesters.
// Latency : one cycle from valid to grant; data path is combinational once granted; one bubble between grants.
// Backpress: out_full stalls the owner (req_ready=0); non-owners always see req_ready=0 and must hold data.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   req_valid/req_last/req_data  per-requester word strobe, end-of-burst flag, packed data
//   req_ready                 per-requester accept (only the owner can be high)
//   out_full                  FIFO full, blocks any write
//   out_wr_en/out_wr_data     FIFO write strobe and data (data is zero when not writing)
//   grant_id/busy             current owner and grant-held flag
module fpio_fifo_in_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          out_full,
  output logic                          out_wr_en,
  output logic [DATA_WIDTH-1:0]         out_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  grant_nxt;
  logic [IDW-1:0]  rr_ptr, rr_nxt;
  logic [CW-1:0]   burst_cnt, cnt_nxt;

  logic [IDW-1:0]        winner;
  logic                  any_valid;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  xfer;
  logic                  burst_end;

  // Round-robin search: first valid index after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 1; k < NUM_REQ + 1; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = idx[IDW-1:0];
      end
    end
  end

  // Owner's signals, selected by grant_id.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign xfer = (state == GRANT) && sel_valid && !out_full;

  // A word flagged last that also fills MAX_BURST still releases only once.
  assign burst_end = sel_last || (int'(burst_cnt) + 1 == MAX_BURST);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      grant_id  <= '0;
      burst_cnt <= '0;
      rr_ptr    <= IDW'(NUM_REQ - 1);
    end else begin
      state     <= state_nxt;
      grant_id  <= grant_nxt;
      burst_cnt <= cnt_nxt;
      rr_ptr    <= rr_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    cnt_nxt   = burst_cnt;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nxt = GRANT;
          grant_nxt = winner;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        // Owner dropping valid or a full FIFO simply holds everything.
        if (xfer) begin
          if (burst_end) begin
            state_nxt = IDLE;
            rr_nxt    = grant_id;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = burst_cnt + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    req_ready   = '0;
    out_wr_en   = 1'b0;
    out_wr_data = '0;
    busy        = (state == GRANT);
    if (state == GRANT) begin
      req_ready[grant_id] = !out_full;
    end
    if (xfer) begin
      out_wr_en   = 1'b1;
      out_wr_data = sel_data;
    end
  end

endmodule

// File: tb/tb_fpio_fifo_in_arbiter.sv
// Purpose : directed self-checking bench for fpio_fifo_in_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
// Latency : inputs driven 1ns after posedge, outputs checked 3ns after posedge.
// Backpress: out_full and owner valid-drop cases exercised explicitly.
module tb_fpio_fifo_in_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_full;
  logic        out_wr_en;
  logic [7:0]  out_wr_data;
  logic [1:0]  grant_id;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int words;

  fpio_fifo_in_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(8),
    .MAX_BURST(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_data(req_data),
    .req_ready(req_ready),
    .out_full(out_full),
    .out_wr_en(out_wr_en),
    .out_wr_data(out_wr_data),
    .grant_id(grant_id),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] d);
    req_data[i*8 +: 8] = d;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    req_last  = '0;
    out_full  = 1'b0;
    cyc();
    rstn = 1'b1;
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_full  = 1'b0;

    // Reset state
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_wr_en", 32'(out_wr_en), 0);
    chk("rst_wr_data", 32'(out_wr_data), 0);
    cyc();
    rstn = 1'b1;

    // Single requester, two-word burst ended by last
    req_valid = 4'b0001;
    set_data(0, 8'h11);
    #2;
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_wr", 32'(out_wr_en), 0);
    chk("t1_idle_ready", 32'(req_ready), 0);
    cyc();
    #2;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_gid", 32'(grant_id), 0);
    chk("t1_ready", 32'(req_ready), 4'b0001);
    chk("t1_w0_en", 32'(out_wr_en), 1);
    chk("t1_w0_dat", 32'(out_wr_data), 8'h11);
    cyc();
    set_data(0, 8'h22);
    req_last = 4'b0001;
    #2;
    chk("t1_w1_en", 32'(out_wr_en), 1);
    chk("t1_w1_dat", 32'(out_wr_data), 8'h22);
    cyc();
    req_valid = '0;
    req_last  = '0;
    #2;
    chk("t1_rel_busy", 32'(busy), 0);
    chk("t1_rel_wr", 32'(out_wr_en), 0);
    chk("t1_rel_dat", 32'(out_wr_data), 0);
    cyc();

    // Round-robin rotation, all valid, MAX_BURST bursts
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 8'hA0 + 8'(i));
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      #2;
      chk("t2_gap_busy", 32'(busy), 0);
      chk("t2_gap_wr", 32'(out_wr_en), 0);
      cyc();
      for (int w = 0; w < 4; w++) begin
        #2;
        chk("t2_busy", 32'(busy), 1);
        chk("t2_gid", 32'(grant_id), 32'(g));
        chk("t2_ready", 32'(req_ready), 32'(1 << g));
        chk("t2_wr", 32'(out_wr_en), 1);
        chk("t2_dat", 32'(out_wr_data), 32'(8'hA0 + 8'(g)));
        cyc();
      end
    end
    #2;
    chk("t2_end_busy", 32'(busy), 0);

    // Owner 2 stalled by out_full mid-burst
    do_reset();
    req_valid = 4'b0100;
    words = 0;
    set_data(2, 8'h30);
    cyc();
    for (int c = 0; c < 7; c++) begin
      out_full = (c >= 2 && c <= 4);
      set_data(2, 8'h30 + 8'(words));
      #2;
      chk("t3_busy", 32'(busy), 1);
      chk("t3_gid", 32'(grant_id), 2);
      if (out_full) begin
        chk("t3_full_wr", 32'(out_wr_en), 0);
        chk("t3_full_ready", 32'(req_ready), 0);
      end else begin
        chk("t3_wr", 32'(out_wr_en), 1);
        chk("t3_dat", 32'(out_wr_data), 32'(8'h30 + 8'(words)));
        chk("t3_ready", 32'(req_ready), 4'b0100);
      end
      if (out_wr_en) words++;
      cyc();
    end
    out_full = 1'b0;
    #2;
    chk("t3_words", 32'(words), 4);
    chk("t3_rel_busy", 32'(busy), 0);

    // Owner 1 drops valid mid-burst while requester 3 waits
    do_reset();
    req_valid = 4'b1010;
    set_data(1, 8'h40);
    set_data(3, 8'h77);
    cyc();
    #2;
    chk("t4_gid", 32'(grant_id), 1);
    chk("t4_w0", 32'(out_wr_data), 8'h40);
    cyc();
    req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      #2;
      chk("t4_hold_busy", 32'(busy), 1);
      chk("t4_hold_gid", 32'(grant_id), 1);
      chk("t4_hold_wr", 32'(out_wr_en), 0);
      chk("t4_hold_ready", 32'(req_ready), 4'b0010);
      cyc();
    end
    req_valid = 4'b1010;
    for (int w = 1; w < 4; w++) begin
      set_data(1, 8'h40 + 8'(w));
      #2;
      chk("t4_wr", 32'(out_wr_en), 1);
      chk("t4_dat", 32'(out_wr_data), 32'(8'h40 + 8'(w)));
      cyc();
    end
    #2;
    chk("t4_rel_busy", 32'(busy), 0);
    cyc();
    #2;
    chk("t4_next_gid", 32'(grant_id), 3);
    chk("t4_next_dat", 32'(out_wr_data), 8'h77);

    // Last flag coincides with the MAX_BURST word
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 8'hC0 + 8'(i));
    cyc();
    for (int w = 0; w < 4; w++) begin
      req_last = (w == 3) ? 4'b0001 : 4'b0000;
      #2;
      chk("t5_gid0", 32'(grant_id), 0);
      chk("t5_wr0", 32'(out_wr_en), 1);
      cyc();
    end
    req_last = '0;
    #2;
    chk("t5_gap", 32'(busy), 0);
    cyc();
    words = 0;
    for (int w = 0; w < 4; w++) begin
      #2;
      chk("t5_gid1", 32'(grant_id), 1);
      chk("t5_dat1", 32'(out_wr_data), 8'hC1);
      if (out_wr_en) words++;
      cyc();
    end
    #2;
    chk("t5_words1", 32'(words), 4);
    chk("t5_rel1", 32'(busy), 0);

    // Asynchronous reset during word 2 of a burst
    do_reset();
    req_valid = 4'b0100;
    set_data(2, 8'h55);
    cyc();
    #2;
    chk("t6_gid", 32'(grant_id), 2);
    chk("t6_w0", 32'(out_wr_en), 1);
    cyc();
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_ar_busy", 32'(busy), 0);
    chk("t6_ar_gid", 32'(grant_id), 0);
    chk("t6_ar_wr", 32'(out_wr_en), 0);
    chk("t6_ar_dat", 32'(out_wr_data), 0);
    chk("t6_ar_ready", 32'(req_ready), 0);
    cyc();
    rstn      = 1'b1;
    req_valid = 4'b1111;
    #2;
    chk("t6_post_busy", 32'(busy), 0);
    cyc();
    #2;
    chk("t6_post_gid", 32'(grant_id), 0);
    chk("t6_post_busy1", 32'(busy), 1);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
